mem_port_arbiter: RTL

Arbitrates the core's single unified memory port between instruction fetch (IF) and the load/store unit (LS). Issues at most one access per cycle and is fully pipelined. Routes each read response back to its owner after the fixed memory latency. Sits between the core pipeline and the memory/cache array and replaces direct wiring of both requesters to memory.

---
 rtl/mem_port_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates IF and LS onto one pipelined memory port and routes responses back by tag.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of LS priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef struct packed {
    logic v;
    logic ls;
    logic we;
  } tag_t;
  tag_t pipe [MEM_LAT];
  tag_t tag_out;
  logic if_wins;
`ifdef MEM_ARB_RR_EN
  logic last_if;
  assign if_wins = !ls_req || !last_if;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_if <= 1'b1;
    else if (if_gnt || ls_gnt) last_if <= if_gnt;
`else
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  assign if_wins = !ls_req || starve_cnt == SMAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_cnt <= '0;
    else if (!if_req || if_gnt) starve_cnt <= '0;
    else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
`endif
  always_comb begin
    if_gnt = if_req && if_wins;
    ls_gnt = ls_req && !if_gnt;
    mem_en = if_gnt || ls_gnt;
    mem_we = ls_gnt && ls_we;
    mem_be = ls_gnt ? ls_be : if_gnt ? {(DATA_W/8){1'b1}} : '0;
    mem_addr = ls_gnt ? ls_addr : if_addr;
    mem_wdata = ls_wdata;
  end
  // Tag pipe mirrors the memory latency so each response exits alongside its data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= {mem_en, ls_gnt, ls_gnt && ls_we};
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  always_comb begin
    tag_out = pipe[MEM_LAT-1];
    if_rvalid = tag_out.v && !tag_out.ls;
    ls_rvalid = tag_out.v && tag_out.ls;
    if_rdata = if_rvalid ? mem_rdata : '0;
    ls_rdata = ls_rvalid && !tag_out.we ? mem_rdata : '0;
  end
endmodule
